// File: rtl/uart_marco_rx.sv
// uart_marco_rx
//   Receive-side front end of the MARCO/POLO responder. Deserialises an 8N1
//   line using an oversampling strobe and watches the good-byte stream for
//   the ASCII sequence "MARCO". The one-cycle match pulse drives the
//   transmitter's send input.
//
// Parameters:
//   OVERSAMPLE  os_tick pulses per bit period (even, >= 4)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   os_tick    in   oversample strobe, one clk wide
//   rx         in   asynchronous UART line, idle high
//   rx_data    out  last correctly framed byte, held until the next good byte
//   rx_valid   out  one-cycle pulse when rx_data updates
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   match      out  one-cycle pulse on the final 'O' of "MARCO"
module uart_marco_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       os_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       match
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic [2:0]    midx;
    logic          rx_meta;
    logic          rxs;

    // Expected byte at each matcher position.
    function automatic logic [7:0] pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    pattern = 8'h4D;  // 'M'
            3'd1:    pattern = 8'h41;  // 'A'
            3'd2:    pattern = 8'h52;  // 'R'
            3'd3:    pattern = 8'h43;  // 'C'
            default: pattern = 8'h4F;  // 'O'
        endcase
    endfunction

    // Both flops reset to the idle level so leaving reset never looks like
    // a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments give every flop the value from
            // before the edge; blocking here would collapse the two stages.
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            midx      <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            match     <= 1'b0;
        end else begin
            // Pulse outputs default low so each is high for one cycle only.
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            match     <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Start detection is immediate; tick alignment is
                    // absorbed by the half-bit wait in START.
                    if (!rxs) begin
                        tcnt  <= '0;
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (os_tick) begin
                        if (tcnt == T_HALF) begin
                            if (!rxs) begin
                                tcnt  <= '0;
                                bcnt  <= '0;
                                state <= S_DATA;
                            end else begin
                                state <= S_IDLE;  // glitch, not a start bit
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (os_tick) begin
                        if (tcnt == T_FULL) begin
                            tcnt  <= '0;
                            shreg <= {rxs, shreg[7:1]};  // LSB arrives first
                            if (bcnt == 3'd7) begin
                                state <= S_STOP;
                            end else begin
                                bcnt <= bcnt + 3'd1;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

                S_STOP: begin
                    if (os_tick) begin
                        if (tcnt == T_FULL) begin
                            tcnt <= '0;
                            if (rxs) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                                if (shreg == pattern(midx)) begin
                                    if (midx == 3'd4) begin
                                        match <= 1'b1;
                                        midx  <= '0;
                                    end else begin
                                        midx <= midx + 3'd1;
                                    end
                                end else if (shreg == 8'h4D) begin
                                    // A stray 'M' may itself begin a new match.
                                    midx <= 3'd1;
                                end else begin
                                    midx <= '0;
                                end
                                state <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                midx      <= '0;
                                state     <= S_BREAK;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

                S_BREAK: begin
                    // A held-low line reports one frame error, not one per
                    // frame time.
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_marco_rx.sv
// Directed bench for uart_marco_rx at OVERSAMPLE = 16 with os_tick every
// fourth clk. A monitor logs every pulse; each test task drives frames and
// compares the log against hand-computed expectations.
module tb_uart_marco_rx;

    logic       clk;
    logic       rst_n;
    logic       os_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       match;

    int total = 0;
    int bad   = 0;

    // Pulse log written by the monitor.
    logic [7:0] got_q[$];
    int         match_at[$];
    int         valid_n, ferr_n, match_n, orphan_n, overlap_n;

    uart_marco_rx #(.OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .os_tick   (os_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .match     (match)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int ph;
        ph      = 0;
        os_tick = 1'b0;
        forever begin
            @(negedge clk);
            ph      = (ph + 1) % 4;
            os_tick = (ph == 0);
        end
    end

    // Sampled on the falling edge, away from the active edge. Counting high
    // cycles (not edges) exposes any pulse that lasts longer than one clk.
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_n++;
            got_q.push_back(rx_data);
        end
        if (frame_err) ferr_n++;
        if (rx_valid && frame_err) overlap_n++;
        if (match) begin
            match_n++;
            match_at.push_back(got_q.size());
            if (!rx_valid) orphan_n++;
        end
    end

    task automatic clear_log();
        got_q.delete();
        match_at.delete();
        valid_n   = 0;
        ferr_n    = 0;
        match_n   = 0;
        orphan_n  = 0;
        overlap_n = 0;
    endtask

    // Advance n oversample ticks, returning just after the last tick edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (os_tick !== 1'b1);
        end
        #1;
    endtask

    // One 8N1 frame. A low stop bit can be stretched by extra_low ticks
    // before the line returns high.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int extra_low);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_ticks(16);
        end
        rx = stop_ok;
        wait_ticks(16);
        if (!stop_ok) begin
            wait_ticks(extra_low);
            rx = 1'b1;
            wait_ticks(4);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rx_data, rx_valid, frame_err, match} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 000", {rx_data, rx_valid, frame_err, match});
        end
        rst_n = 1'b1;
        wait_ticks(1000);
        total++;
        if (valid_n + ferr_n + match_n !== 0) begin
            bad++;
            $display("FAIL idle_pulses: got %0d want 0", valid_n + ferr_n + match_n);
        end
        total++;
        if (rx_data !== 8'h00) begin
            bad++;
            $display("FAIL idle_rx_data: got %h want 00", rx_data);
        end
    endtask

    // Back-to-back frames of s; exactly one match expected, on byte exp_pos (1-based).
    task automatic test_string(input string name, input string s, input int exp_pos);
        clear_log();
        send_str(s);
        wait_ticks(4);
        total++;
        if (valid_n !== s.len()) begin
            bad++;
            $display("FAIL %s valid_count: got %0d want %0d", name, valid_n, s.len());
        end
        for (int i = 0; i < s.len(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== s[i]) begin
                bad++;
                $display("FAIL %s byte%0d: got %h want %h", name, i,
                         (i < got_q.size()) ? got_q[i] : 8'hxx, s[i]);
            end
        end
        total++;
        if (match_n !== 1) begin
            bad++;
            $display("FAIL %s match_count: got %0d want 1", name, match_n);
        end
        total++;
        if (match_at.size() < 1 || match_at[0] !== exp_pos) begin
            bad++;
            $display("FAIL %s match_pos: got %0d want %0d",
                     name, (match_at.size() > 0) ? match_at[0] : -1, exp_pos);
        end
        total++;
        if (orphan_n !== 0) begin
            bad++;
            $display("FAIL %s match_without_valid: got %0d want 0", name, orphan_n);
        end
        total++;
        if (rx_data !== s[s.len()-1]) begin
            bad++;
            $display("FAIL %s rx_data_hold: got %h want %h", name, rx_data, s[s.len()-1]);
        end
    endtask

    task automatic test_glitch();
        clear_log();
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(20);
        total++;
        if (valid_n + ferr_n + match_n !== 0) begin
            bad++;
            $display("FAIL glitch_pulses: got %0d want 0", valid_n + ferr_n + match_n);
        end
        send_byte(8'h55, 1'b1, 0);
        wait_ticks(4);
        total++;
        if (valid_n !== 1 || got_q.size() < 1 || got_q[0] !== 8'h55) begin
            bad++;
            $display("FAIL glitch_followup: got count=%0d data=%h want count=1 data=55", valid_n, rx_data);
        end
        total++;
        if (ferr_n !== 0) begin
            bad++;
            $display("FAIL glitch_followup_ferr: got %0d want 0", ferr_n);
        end
    endtask

    task automatic test_frame_err();
        clear_log();
        send_byte(8'h4D, 1'b0, 0);
        total++;
        if (ferr_n !== 1 || valid_n !== 0) begin
            bad++;
            $display("FAIL ferr_single: got ferr=%0d valid=%0d want ferr=1 valid=0", ferr_n, valid_n);
        end
        total++;
        if (rx_data !== 8'h55) begin
            bad++;
            $display("FAIL ferr_rx_data_kept: got %h want 55", rx_data);
        end
        // A good 'M' arms the matcher; the bad frame must disarm it.
        send_byte(8'h4D, 1'b1, 0);
        send_byte(8'h4D, 1'b0, 48);
        total++;
        if (ferr_n !== 2) begin
            bad++;
            $display("FAIL ferr_held_low: got %0d want 2", ferr_n);
        end
        send_str("ARCO");
        wait_ticks(4);
        total++;
        if (match_n !== 0) begin
            bad++;
            $display("FAIL ferr_no_match: got %0d want 0", match_n);
        end
        total++;
        if (valid_n !== 5 || rx_data !== 8'h4F) begin
            bad++;
            $display("FAIL ferr_recover: got count=%0d data=%h want count=5 data=4f", valid_n, rx_data);
        end
        total++;
        if (overlap_n !== 0) begin
            bad++;
            $display("FAIL ferr_valid_overlap: got %0d want 0", overlap_n);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        b = 8'h4F;
        clear_log();
        send_str("MARC");
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_ticks(16);
        end
        rx = b[4];
        wait_ticks(8);
        rst_n = 1'b0;
        #1;
        total++;
        if ({rx_data, rx_valid, frame_err, match} !== 11'h0) begin
            bad++;
            $display("FAIL async_reset_outputs: got %h want 000", {rx_data, rx_valid, frame_err, match});
        end
        rx = 1'b1;
        wait_ticks(10);
        rst_n = 1'b1;
        wait_ticks(20);
        total++;
        if (valid_n !== 4 || ferr_n !== 0 || match_n !== 0) begin
            bad++;
            $display("FAIL async_reset_partial: got valid=%0d ferr=%0d match=%0d want 4 0 0",
                     valid_n, ferr_n, match_n);
        end
        send_byte(8'h4F, 1'b1, 0);
        wait_ticks(4);
        total++;
        if (valid_n !== 5 || rx_data !== 8'h4F) begin
            bad++;
            $display("FAIL async_reset_o_rx: got count=%0d data=%h want count=5 data=4f", valid_n, rx_data);
        end
        total++;
        if (match_n !== 0) begin
            bad++;
            $display("FAIL async_reset_no_match: got %0d want 0", match_n);
        end
    endtask

    initial begin
        test_reset();
        test_string("marco", "MARCO", 5);
        test_string("mamarco", "MAMARCO", 7);
        test_string("marxmarco", "MARXMARCO", 9);
        test_string("mmarco", "MMARCO", 6);
        test_string("marc_marco", "MARCMARCO", 9);
        test_glitch();
        test_frame_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_marco_rx.md
# uart_marco_rx

Receive-side front end of the MARCO/POLO UART responder. It deserialises the RX line using an oversampling tick and assembles 8N1 bytes. It scans the byte stream for the ASCII sequence "MARCO" (0x4D 0x41 0x52 0x43 0x4F) and emits a one-cycle `match` pulse. `match` drives the `send` input of the downstream transmitter, which then replies with its hardcoded message.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: `os_tick` pulses per bit period. Must be even and ≥ 4. The tick counter width is clog2(OVERSAMPLE).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `os_tick`  in  1  oversample strobe, one `clk` cycle wide, OVERSAMPLE× baud rate (153.6 kHz for 9600 baud)
- `rx`  in  1  asynchronous UART line, idle high
- `rx_data`  out  8  last correctly framed byte; holds its value until the next good byte
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low
- `match`  out  1  one-cycle pulse when the final 'O' of "MARCO" is received; connects to the transmitter `send`

## Operation
- Input synchroniser:
  - 2-FF synchroniser on `rx`, both flops reset to 1.
  - All logic below uses the synchronised value `rxs`.
- Receiver state machine (`os_tick` gates all counting; a tick counter `tcnt` and bit counter `bcnt` are used):
  - IDLE: when `rxs` == 0, clear `tcnt` → START. Detection does not wait for `os_tick`.
  - START: on each tick, `tcnt`++.
    - When `tcnt` reaches OVERSAMPLE/2−1 on a tick (mid start bit), sample `rxs`.
    - If `rxs` is 0: clear `tcnt` and `bcnt` → DATA.
    - If `rxs` is 1 (glitch, false start): → IDLE with no output.
  - DATA: on the tick where `tcnt` == OVERSAMPLE−1, sample `rxs` into the shift register LSB-first (shift right, new bit into bit 7) and clear `tcnt`.
    - After the 8th sample (`bcnt` == 7) → STOP; otherwise `bcnt`++.
  - STOP: on the tick where `tcnt` == OVERSAMPLE−1, sample `rxs`.
    - If 1: `rx_data` ← shift register, pulse `rx_valid`, update the matcher → IDLE.
    - If 0: pulse `frame_err`, leave `rx_data` unchanged, reset the matcher index to 0 → BREAK.
  - BREAK: wait until `rxs` == 1 → IDLE. A line held low generates exactly one `frame_err`.
  - Illegal state encodings → IDLE.
- Matcher (3-bit index `midx`, 0..4), evaluated only on good bytes:
  - byte == pattern[`midx`] and `midx` == 4: pulse `match`, `midx` ← 0.
  - byte == pattern[`midx`] and `midx` < 4: `midx`++.
  - Otherwise, byte == 0x4D ('M'): `midx` ← 1.
  - Otherwise: `midx` ← 0.
  - The comparison is case-sensitive. "MMARCO" and "xMARCO" match; "MARC" followed by "MARCO" matches exactly once.
- `match` fires regardless of transmitter `busy`. The transmitter ignores `send` while busy; no queuing is done here.

## Timing
- Reset values:
  - `rx_data` = 0x00; `rx_valid`, `frame_err`, `match` = 0.
  - State IDLE; `midx`, `tcnt`, `bcnt` = 0; synchroniser flops = 1.
- Synchroniser latency: 2 `clk` cycles from `rx` to `rxs`.
- `rx_valid`, `rx_data` and `match` are registered and update on the same `clk` edge as the stop-bit sample. `match` and `rx_valid` are therefore coincident.
- `frame_err` is registered on the stop-bit sample edge and is mutually exclusive with `rx_valid`.
- Each pulse output is high for exactly one `clk` cycle.
- Back-to-back frames: a start edge arriving in the cycle right after the return to IDLE is accepted. There is no dead time beyond one `clk` cycle.
- Sampling points sit at the bit centre ±1 tick. This tolerates ±4% baud mismatch at OVERSAMPLE = 16.
- Asynchronous reset mid-frame returns everything to the reset values immediately. A partially received byte is discarded and produces no pulse.

## Test plan
- Reset then idle line for 1000 ticks → all outputs 0, no pulses.
- Send 0x4D, 0x41, 0x52, 0x43, 0x4F at 9600 baud with OVERSAMPLE = 16 → five `rx_valid` pulses with matching `rx_data`, and exactly one `match` coincident with the 0x4F `rx_valid`.
- Send "MAMARCO", then "MARXMARCO" → exactly one `match` per string, each on the final 'O'; no `match` on any earlier byte.
- Low glitch of 4 ticks on `rx` → no `rx_valid`, no `frame_err`, FSM back in IDLE. A following 0x55 frame is received correctly.
- Frame 0x4D with the stop bit forced low, then "ARCO" → one `frame_err`, `rx_data` not updated, no `match`. Then hold `rx` low for 3 bit times → still only one `frame_err`.
- Assert `rst_n` low during bit 4 of 0x4F after "MARC" → outputs return to reset values. Send "O" after release → no `match`, because `midx` was cleared.
